// File: rtl/lc4_wb_arbiter_pkg.sv
// Shared types and constants for the LC4 register-file write-port arbiter.
package lc4_wb_arbiter_pkg;

  localparam int REG_IDX_W = 3;
  localparam int NUM_REGS  = 8;

  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_FORCE  = 1'b1
  } arb_state_e;

  function automatic logic [3:0] popcount8(input logic [NUM_REGS-1:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      c = c + {3'b000, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/lc4_wb_arbiter_if.sv
// Writeback bundle between the W stage / long-latency unit, decode and the regfile write port.
interface lc4_wb_arbiter_if #(parameter int n = 16);
  import lc4_wb_arbiter_pkg::*;

  logic                 i_a_we;
  logic [REG_IDX_W-1:0] i_a_rd;
  logic [n-1:0]         i_a_wdata;
  logic                 i_b_issue;
  logic [REG_IDX_W-1:0] i_b_issue_rd;
  logic                 o_b_issue_ok;
  logic                 i_b_valid;
  logic [REG_IDX_W-1:0] i_b_rd;
  logic [n-1:0]         i_b_wdata;
  logic                 o_b_ready;
  logic [REG_IDX_W-1:0] i_rs;
  logic [REG_IDX_W-1:0] i_rt;
  logic                 o_rs_busy;
  logic                 o_rt_busy;
  logic                 o_stall_a;
  logic [NUM_REGS-1:0]  o_pending;
  logic [REG_IDX_W-1:0] o_rd;
  logic [n-1:0]         o_wdata;
  logic                 o_rd_we;
  logic                 o_waw_err;

  modport slave (
    input  i_a_we, i_a_rd, i_a_wdata, i_b_issue, i_b_issue_rd,
           i_b_valid, i_b_rd, i_b_wdata, i_rs, i_rt,
    output o_b_issue_ok, o_b_ready, o_rs_busy, o_rt_busy, o_stall_a,
           o_pending, o_rd, o_wdata, o_rd_we, o_waw_err
  );

  modport master (
    output i_a_we, i_a_rd, i_a_wdata, i_b_issue, i_b_issue_rd,
           i_b_valid, i_b_rd, i_b_wdata, i_rs, i_rt,
    input  o_b_issue_ok, o_b_ready, o_rs_busy, o_rt_busy, o_stall_a,
           o_pending, o_rd, o_wdata, o_rd_we, o_waw_err
  );

endinterface

// File: rtl/lc4_wb_scoreboard.sv
// Pending-write scoreboard for long-latency results; busy/issue_ok are combinational,
// pending bits update on gwe-qualified edges.
module lc4_wb_scoreboard
  import lc4_wb_arbiter_pkg::*;
#(
  parameter int MAX_PENDING = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 gwe_i,
  input  logic                 issue_i,
  input  logic [REG_IDX_W-1:0] issue_rd_i,
  input  logic                 clr_i,
  input  logic [REG_IDX_W-1:0] clr_rd_i,
  input  logic [REG_IDX_W-1:0] rs_i,
  input  logic [REG_IDX_W-1:0] rt_i,
  output logic                 issue_ok_o,
  output logic                 rs_busy_o,
  output logic                 rt_busy_o,
  output logic [NUM_REGS-1:0]  pending_o
);

  localparam logic [3:0] MAX_P = 4'(MAX_PENDING);

  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic [NUM_REGS-1:0] clr_mask, set_mask;
  logic [3:0]          count_after_clr;

  assign clr_mask = clr_i ? (NUM_REGS'(1) << clr_rd_i) : '0;

  // A slot freed by this cycle's writeback can be reused by a same-cycle issue;
  // the per-register check stays on the raw bit so one register never sets and clears at once.
  assign count_after_clr = popcount8(pending_q & ~clr_mask);
  assign issue_ok_o      = !pending_q[issue_rd_i] && (count_after_clr < MAX_P);

  assign set_mask  = (issue_i && issue_ok_o) ? (NUM_REGS'(1) << issue_rd_i) : '0;
  assign pending_d = (pending_q & ~clr_mask) | set_mask;

  assign rs_busy_o = pending_q[rs_i] & ~clr_mask[rs_i];
  assign rt_busy_o = pending_q[rt_i] & ~clr_mask[rt_i];
  assign pending_o = pending_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_q <= '0;
    end else if (gwe_i) begin
      pending_q <= pending_d;
    end
  end

endmodule

// File: rtl/lc4_wb_arbiter.sv
// Arbitrates the single regfile write port between W-stage writeback (A) and a long-latency unit (B).
// Zero-latency combinational grant; A has priority, B is force-granted after STARVE_LIMIT denials.
module lc4_wb_arbiter
  import lc4_wb_arbiter_pkg::*;
#(
  parameter int n            = 16,
  parameter int STARVE_LIMIT = 4,
  parameter int MAX_PENDING  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   gwe,
  lc4_wb_arbiter_if.slave        bus
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);

  arb_state_e          state_q, state_d;
  logic [3:0]          starve_q, starve_d;
  logic                waw_q, waw_d;
  logic                grant_a, grant_b, stall;
  logic [NUM_REGS-1:0] pending;

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    grant_a  = 1'b0;
    grant_b  = 1'b0;
    stall    = 1'b0;
    case (state_q)
      ST_NORMAL: begin
        grant_a = bus.i_a_we;
        grant_b = !bus.i_a_we && bus.i_b_valid;
        if (bus.i_b_valid && !grant_b) begin
          if (starve_q + 4'd1 == STARVE_LIM) begin
            state_d  = ST_FORCE;
            starve_d = '0;
          end else begin
            starve_d = starve_q + 4'd1;
          end
        end else begin
          starve_d = '0;
        end
      end
      ST_FORCE: begin
        stall    = 1'b1;
        grant_b  = bus.i_b_valid;
        starve_d = '0;
        state_d  = ST_NORMAL;
      end
      default: state_d = ST_NORMAL;
    endcase
    // No write reaches the regfile while reset is held, whatever the inputs say.
    if (!rst) begin
      grant_a = 1'b0;
      grant_b = 1'b0;
    end
  end

  assign waw_d = waw_q | (grant_a & pending[bus.i_a_rd]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_NORMAL;
      starve_q <= '0;
      waw_q    <= 1'b0;
    end else if (gwe) begin
      state_q  <= state_d;
      starve_q <= starve_d;
      waw_q    <= waw_d;
    end
  end

  lc4_wb_scoreboard #(.MAX_PENDING(MAX_PENDING)) u_sb (
    .clk        (clk),
    .rst        (rst),
    .gwe_i      (gwe),
    .issue_i    (bus.i_b_issue),
    .issue_rd_i (bus.i_b_issue_rd),
    .clr_i      (grant_b),
    .clr_rd_i   (bus.i_b_rd),
    .rs_i       (bus.i_rs),
    .rt_i       (bus.i_rt),
    .issue_ok_o (bus.o_b_issue_ok),
    .rs_busy_o  (bus.o_rs_busy),
    .rt_busy_o  (bus.o_rt_busy),
    .pending_o  (pending)
  );

  assign bus.o_pending = pending;
  assign bus.o_rd      = grant_a ? bus.i_a_rd    : (grant_b ? bus.i_b_rd    : '0);
  assign bus.o_wdata   = grant_a ? bus.i_a_wdata : (grant_b ? bus.i_b_wdata : '0);
  assign bus.o_rd_we   = grant_a | grant_b;
  assign bus.o_b_ready = grant_b;
  assign bus.o_stall_a = stall;
  assign bus.o_waw_err = waw_q;

endmodule

// File: tb/tb_lc4_wb_arbiter.sv
// Bench for lc4_wb_arbiter: directed scenarios plus random traffic against a rule-level model.
module tb_lc4_wb_arbiter;
  import lc4_wb_arbiter_pkg::*;

  localparam int N  = 16;
  localparam int SL = 4;
  localparam int MP = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic gwe = 1'b1;
  always #5 clk = ~clk;

  lc4_wb_arbiter_if #(.n(N)) bus ();

  lc4_wb_arbiter #(.n(N), .STARVE_LIMIT(SL), .MAX_PENDING(MP)) dut (
    .clk (clk),
    .rst (rst),
    .gwe (gwe),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Model state: set of registers owed by B, denied-cycle run length, forced-cycle flag, sticky error.
  bit [7:0] m_pend;
  int       m_starve;
  bit       m_force;
  bit       m_waw;

  bit         e_ga, e_gb, e_ok, e_rs, e_rt;
  logic [2:0] e_rd;
  logic [N-1:0] e_wd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = '0; m_starve = 0; m_force = 1'b0; m_waw = 1'b0;
  endtask

  task automatic model_eval();
    int cnt;
    e_ga = rst && !m_force && bus.i_a_we;
    e_gb = rst && bus.i_b_valid && (m_force || !bus.i_a_we);
    e_rd = e_ga ? bus.i_a_rd : (e_gb ? bus.i_b_rd : 3'd0);
    e_wd = e_ga ? bus.i_a_wdata : (e_gb ? bus.i_b_wdata : '0);
    cnt  = $countones(m_pend) - ((e_gb && m_pend[bus.i_b_rd]) ? 1 : 0);
    e_ok = !m_pend[bus.i_b_issue_rd] && (cnt < MP);
    e_rs = m_pend[bus.i_rs] && !(e_gb && bus.i_b_rd == bus.i_rs);
    e_rt = m_pend[bus.i_rt] && !(e_gb && bus.i_b_rd == bus.i_rt);
  endtask

  task automatic check_all();
    model_eval();
    chk("rd",       32'(bus.o_rd),         32'(e_rd));
    chk("wdata",    32'(bus.o_wdata),      32'(e_wd));
    chk("rd_we",    32'(bus.o_rd_we),      32'(e_ga | e_gb));
    chk("b_ready",  32'(bus.o_b_ready),    32'(e_gb));
    chk("stall_a",  32'(bus.o_stall_a),    32'(m_force));
    chk("pending",  32'(bus.o_pending),    32'(m_pend));
    chk("waw_err",  32'(bus.o_waw_err),    32'(m_waw));
    chk("issue_ok", 32'(bus.o_b_issue_ok), 32'(e_ok));
    chk("rs_busy",  32'(bus.o_rs_busy),    32'(e_rs));
    chk("rt_busy",  32'(bus.o_rt_busy),    32'(e_rt));
  endtask

  task automatic model_commit();
    bit [7:0] nxt;
    if (rst && gwe) begin
      nxt = m_pend;
      if (e_gb) nxt[bus.i_b_rd] = 1'b0;
      if (bus.i_b_issue && e_ok) nxt[bus.i_b_issue_rd] = 1'b1;
      if (e_ga && m_pend[bus.i_a_rd]) m_waw = 1'b1;
      if (m_force) begin
        m_force = 1'b0; m_starve = 0;
      end else if (bus.i_b_valid && !e_gb) begin
        m_starve++;
        if (m_starve == SL) begin m_force = 1'b1; m_starve = 0; end
      end else begin
        m_starve = 0;
      end
      m_pend = nxt;
    end
  endtask

  task automatic settle();
    @(negedge clk);
    check_all();
  endtask

  task automatic tick();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic idle();
    bus.i_a_we = 1'b0; bus.i_a_rd = '0; bus.i_a_wdata = '0;
    bus.i_b_issue = 1'b0; bus.i_b_issue_rd = '0;
    bus.i_b_valid = 1'b0; bus.i_b_rd = '0; bus.i_b_wdata = '0;
    bus.i_rs = '0; bus.i_rt = '0;
  endtask

  function automatic logic [2:0] pick_pending(input int start);
    logic [2:0] r;
    bit found;
    r = 3'(start);
    found = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (!found && m_pend[(start + k) % 8]) begin
        r = 3'((start + k) % 8);
        found = 1'b1;
      end
    end
    return r;
  endfunction

  initial begin
    idle();
    model_reset();
    #2;
    chk("rst_stall",   32'(bus.o_stall_a), 32'd0);
    chk("rst_rd_we",   32'(bus.o_rd_we),   32'd0);
    chk("rst_b_ready", 32'(bus.o_b_ready), 32'd0);
    chk("rst_pending", 32'(bus.o_pending), 32'd0);
    chk("rst_waw",     32'(bus.o_waw_err), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;

    // A write with B idle
    bus.i_a_we = 1'b1; bus.i_a_rd = 3'd3; bus.i_a_wdata = 16'h1234;
    settle();
    chk("a_rd", 32'(bus.o_rd), 32'd3);
    chk("a_wdata", 32'(bus.o_wdata), 32'h1234);
    chk("a_rd_we", 32'(bus.o_rd_we), 32'd1);
    chk("a_b_ready", 32'(bus.o_b_ready), 32'd0);
    tick();

    // B issue to R5 then writeback with clear-bypass on rs
    idle(); bus.i_b_issue = 1'b1; bus.i_b_issue_rd = 3'd5;
    settle(); chk("issue5_ok", 32'(bus.o_b_issue_ok), 32'd1); tick();
    idle(); bus.i_rs = 3'd5;
    settle(); chk("pend5_set", 32'(bus.o_pending[5]), 32'd1); chk("rs5_busy", 32'(bus.o_rs_busy), 32'd1); tick();
    bus.i_b_valid = 1'b1; bus.i_b_rd = 3'd5; bus.i_b_wdata = 16'hBEEF;
    settle();
    chk("b5_ready", 32'(bus.o_b_ready), 32'd1);
    chk("b5_wdata", 32'(bus.o_wdata), 32'hBEEF);
    chk("rs5_bypass", 32'(bus.o_rs_busy), 32'd0);
    tick();
    idle(); settle(); chk("pend5_clr", 32'(bus.o_pending[5]), 32'd0); tick();

    // Starvation: A every cycle, B valid -> 4 denials then forced B grant
    bus.i_a_we = 1'b1; bus.i_a_rd = 3'd1; bus.i_a_wdata = 16'h00A1;
    bus.i_b_valid = 1'b1; bus.i_b_rd = 3'd6; bus.i_b_wdata = 16'h0B06;
    for (int i = 0; i < SL; i++) begin
      settle();
      chk("starve_deny", 32'(bus.o_b_ready), 32'd0);
      chk("starve_nostall", 32'(bus.o_stall_a), 32'd0);
      tick();
    end
    settle();
    chk("force_stall", 32'(bus.o_stall_a), 32'd1);
    chk("force_b", 32'(bus.o_b_ready), 32'd1);
    chk("force_rd", 32'(bus.o_rd), 32'd6);
    tick();
    settle();
    chk("resume_stall", 32'(bus.o_stall_a), 32'd0);
    chk("resume_rd", 32'(bus.o_rd), 32'd1);
    tick();
    idle(); settle(); tick();

    // Fill scoreboard to MAX_PENDING
    for (int r = 1; r <= 4; r++) begin
      idle(); bus.i_b_issue = 1'b1; bus.i_b_issue_rd = 3'(r);
      settle(); tick();
    end
    bus.i_b_issue_rd = 3'd6; settle(); chk("full_ok6", 32'(bus.o_b_issue_ok), 32'd0); tick();
    bus.i_b_issue_rd = 3'd2; settle(); chk("pend_ok2", 32'(bus.o_b_issue_ok), 32'd0); tick();
    bus.i_b_issue_rd = 3'd6; bus.i_b_valid = 1'b1; bus.i_b_rd = 3'd1; bus.i_b_wdata = 16'h0111;
    settle(); chk("swap_ok6", 32'(bus.o_b_issue_ok), 32'd1); tick();
    idle(); settle(); chk("swap_set", 32'(bus.o_pending), 32'h5C); tick();

    // A writes a register B still owns
    bus.i_a_we = 1'b1; bus.i_a_rd = 3'd2; bus.i_a_wdata = 16'h2222;
    settle(); chk("waw_write", 32'(bus.o_rd_we), 32'd1); tick();
    idle(); settle(); chk("waw_set", 32'(bus.o_waw_err), 32'd1); tick();
    settle(); chk("waw_sticky", 32'(bus.o_waw_err), 32'd1); tick();

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      gwe = ($urandom_range(9) != 0);
      bus.i_a_we = ($urandom_range(2) != 0);
      bus.i_a_rd = 3'($urandom_range(7));
      bus.i_a_wdata = 16'($urandom);
      bus.i_b_issue = $urandom_range(1) == 1;
      bus.i_b_issue_rd = 3'($urandom_range(7));
      bus.i_b_valid = ($urandom_range(3) != 0);
      bus.i_b_rd = ($urandom_range(4) != 0) ? pick_pending(int'($urandom_range(7))) : 3'($urandom_range(7));
      bus.i_b_wdata = 16'($urandom);
      bus.i_rs = 3'($urandom_range(7));
      bus.i_rt = 3'($urandom_range(7));
      settle();
      tick();
    end
    gwe = 1'b1;

    // Async reset in the middle of a forced cycle, frozen by gwe=0
    idle(); rst = 1'b0; model_reset(); tick(); rst = 1'b1;
    bus.i_b_issue = 1'b1; bus.i_b_issue_rd = 3'd7; settle(); tick();
    idle();
    bus.i_a_we = 1'b1; bus.i_a_rd = 3'd0; bus.i_a_wdata = 16'h0C0C;
    bus.i_b_valid = 1'b1; bus.i_b_rd = 3'd7; bus.i_b_wdata = 16'h0777;
    for (int i = 0; i < SL; i++) begin settle(); tick(); end
    gwe = 1'b0;
    settle(); chk("frz_stall", 32'(bus.o_stall_a), 32'd1); tick();
    settle(); chk("frz_pend7", 32'(bus.o_pending[7]), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_stall",   32'(bus.o_stall_a), 32'd0);
    chk("arst_rd_we",   32'(bus.o_rd_we),   32'd0);
    chk("arst_b_ready", 32'(bus.o_b_ready), 32'd0);
    chk("arst_pending", 32'(bus.o_pending), 32'd0);
    chk("arst_waw",     32'(bus.o_waw_err), 32'd0);
    model_reset();
    gwe = 1'b1;
    tick();
    rst = 1'b1;
    idle(); settle(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
